tx_ctrl_arb: RTL

Parametrised USB link-layer TX arbiter that generalises the TX control path to one token/handshake source and NCH data sources with configurable byte-lane width. Selects one source per packet, keeps every packet atomic, and drives the PHY through a registered, full-throughput valid/ready stage. Sits between `crc5_t`, the per-endpoint data streams and the PHY, under `link_control` supervision.

---
 rtl/tx_ctrl_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tx_ctrl_arb.sv
// USB link-layer TX arbiter: one token/handshake source plus NCH data channels
// into a registered valid/ready PHY stage. Define TX_CANCEL_EN to enable data-packet cancel.
module tx_ctrl_arb #(
  parameter int DW  = 8,
  parameter int NCH = 2,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_data_on,
  input  logic [SW-1:0]     tx_data_sel,
  output logic              tx_lp_eop_en,
  input  logic              tx_to_sop,
  input  logic              tx_to_eop,
  input  logic              tx_to_valid,
  input  logic [DW-1:0]     tx_to_data,
  output logic              tx_to_ready,
  input  logic [NCH-1:0]    tx_lt_sop,
  input  logic [NCH-1:0]    tx_lt_eop,
  input  logic [NCH-1:0]    tx_lt_valid,
  input  logic [NCH-1:0]    tx_lt_cancle,
  input  logic [NCH*DW-1:0] tx_lt_data,
  output logic [NCH-1:0]    tx_lt_ready,
  output logic              tx_lp_sop,
  output logic              tx_lp_eop,
  output logic              tx_lp_valid,
  output logic              tx_lp_cancle,
  output logic [DW-1:0]     tx_lp_data,
  input  logic              tx_lp_ready
);

  typedef enum logic [1:0] {IDLE, TOKEN, DATA} state_t;

  state_t          state_reg;
  logic [SW-1:0]   lch_reg;
  logic            ov_reg;
  logic            osop_reg;
  logic            oeop_reg;
  logic [DW-1:0]   odata_reg;
  logic            oorg_reg;
  logic            eop_en_reg;
  logic            cancel_reg;

  logic            free;
  logic            use_data;
  logic [SW-1:0]   chan;
  logic            lt_valid_c;
  logic            lt_sop_c;
  logic            lt_eop_c;
  logic            lt_cancel_c;
  logic [DW-1:0]   lt_data_c;
  logic            src_valid;
  logic            src_sop;
  logic            src_eop;
  logic [DW-1:0]   src_data;
  logic            src_ready;
  logic            cancel_hit;
  logic            load;

  assign free = !ov_reg || tx_lp_ready;

  // The data path is eligible in DATA, or in IDLE while link_control grants a data phase.
  always_comb begin
    use_data    = (state_reg == DATA) || ((state_reg == IDLE) && tx_data_on);
    chan        = (state_reg == DATA) ? lch_reg : tx_data_sel;
    lt_valid_c  = 1'b0;
    lt_sop_c    = 1'b0;
    lt_eop_c    = 1'b0;
    lt_cancel_c = 1'b0;
    lt_data_c   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chan == SW'(i)) begin
        lt_valid_c  = tx_lt_valid[i];
        lt_sop_c    = tx_lt_sop[i];
        lt_eop_c    = tx_lt_eop[i];
        lt_cancel_c = tx_lt_cancle[i];
        lt_data_c   = tx_lt_data[i*DW +: DW];
      end
    end
  end

`ifdef TX_CANCEL_EN
  assign cancel_hit = (state_reg == DATA) && lt_cancel_c;
`else
  logic unused_cancel;
  assign unused_cancel = lt_cancel_c;
  assign cancel_hit    = 1'b0;
`endif

  always_comb begin
    src_valid = use_data ? lt_valid_c : tx_to_valid;
    src_sop   = use_data ? lt_sop_c   : tx_to_sop;
    src_eop   = use_data ? lt_eop_c   : tx_to_eop;
    src_data  = use_data ? lt_data_c  : tx_to_data;
    // Stray (non-sop) beats in IDLE and beats hit by a cancel are swallowed unconditionally.
    if (state_reg == IDLE)
      src_ready = src_sop ? free : 1'b1;
    else
      src_ready = free;
    if (cancel_hit)
      src_ready = 1'b1;
    src_ready = src_ready && rst_n;
    load      = src_valid && src_ready && !cancel_hit &&
                ((state_reg != IDLE) || src_sop);
  end

  assign tx_to_ready = src_ready && !use_data;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign tx_lt_ready[gi] = src_ready && use_data && (chan == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      lch_reg    <= '0;
      ov_reg     <= 1'b0;
      osop_reg   <= 1'b0;
      oeop_reg   <= 1'b0;
      odata_reg  <= '0;
      oorg_reg   <= 1'b0;
      eop_en_reg <= 1'b0;
      cancel_reg <= 1'b0;
    end else begin
      eop_en_reg <= ov_reg && tx_lp_ready && oeop_reg && oorg_reg;
      cancel_reg <= cancel_hit;
      if (cancel_hit) begin
        ov_reg    <= 1'b0;
        state_reg <= IDLE;
      end else if (load) begin
        ov_reg    <= 1'b1;
        osop_reg  <= src_sop;
        oeop_reg  <= src_eop;
        odata_reg <= src_data;
        oorg_reg  <= use_data;
        case (state_reg)
          IDLE: begin
            if (!src_eop) begin
              state_reg <= use_data ? DATA : TOKEN;
              if (use_data)
                lch_reg <= tx_data_sel;
            end
          end
          default: begin
            if (src_eop)
              state_reg <= IDLE;
          end
        endcase
      end else if (tx_lp_ready) begin
        ov_reg <= 1'b0;
      end
    end
  end

  assign tx_lp_valid  = ov_reg;
  assign tx_lp_sop    = osop_reg;
  assign tx_lp_eop    = oeop_reg;
  assign tx_lp_data   = odata_reg;
  assign tx_lp_eop_en = eop_en_reg;
  assign tx_lp_cancle = cancel_reg;

endmodule
